// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - MIPS execute stage: ALU control, ALU, PC adders, latched N/Z/V flags
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sext_imm,
    input  logic             status_we,
    output logic [2:0]       alu_ctl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt_bit;
    logic             ovf;
    logic             flag_n_q, flag_n_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_v_q, flag_v_d;
    logic             unused_funct_hi;
    logic             unused_imm_hi;

    // funct[5:4] never affects decode; only funct[3:0] selects the R-type op
    assign unused_funct_hi = ^funct[5:4];
    assign unused_imm_hi   = ^sext_imm[WIDTH-1:WIDTH-2];

    always_comb begin
        alu_ctl = OP_ADD;
        case (aluop)
            2'b00: alu_ctl = OP_ADD;
            2'b01: alu_ctl = OP_SUB;
            2'b11: alu_ctl = OP_ADD;
            default: begin
                case (funct[3:0])
                    4'b0000: alu_ctl = OP_ADD;
                    4'b0010: alu_ctl = OP_SUB;
                    4'b0100: alu_ctl = OP_AND;
                    4'b0101: alu_ctl = OP_OR;
                    4'b0111: alu_ctl = OP_NOR;
                    4'b1010: alu_ctl = OP_SLT;
                    default: alu_ctl = OP_ADD;
                endcase
            end
        endcase
    end

    assign sum  = a + b;
    assign diff = a - b;

    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // Sign of the difference is wrong exactly when the subtraction overflows
    assign slt_bit = diff[WIDTH-1] ^ ovf_sub;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (alu_ctl)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = sum;
                ovf    = ovf_add;
            end
            OP_SUB: begin
                result = diff;
                ovf    = ovf_sub;
            end
            OP_NOR: result = ~(a | b);
            OP_SLT: result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    assign pc_plus4      = pc + WIDTH'(4);
    assign branch_target = pc_plus4 + {sext_imm[WIDTH-3:0], 2'b00};

    always_comb begin
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        flag_v_d = flag_v_q;
        if (status_we) begin
            flag_n_d = result[WIDTH-1];
            flag_z_d = zero;
            flag_v_d = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;
    assign flag_v = flag_v_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed and randomized checks of alu_exec_unit against an arithmetic model
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b, pc, sext_imm;
    logic        status_we;
    logic [2:0]  alu_ctl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] pc_plus4, branch_target;
    logic        flag_n, flag_z, flag_v;

    int checks = 0;
    int errors = 0;
    logic exp_n = 1'b0, exp_z = 1'b0, exp_v = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .pc(pc), .sext_imm(sext_imm), .status_we(status_we),
        .alu_ctl(alu_ctl), .result(result), .zero(zero),
        .pc_plus4(pc_plus4), .branch_target(branch_target),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
    );

    function automatic logic [2:0] ref_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd1) return 3'b110;
        if (op != 2'd2) return 3'b010;
        if (f[3:0] == 4'd2)  return 3'b110;
        if (f[3:0] == 4'd4)  return 3'b000;
        if (f[3:0] == 4'd5)  return 3'b001;
        if (f[3:0] == 4'd7)  return 3'b100;
        if (f[3:0] == 4'd10) return 3'b111;
        return 3'b010;
    endfunction

    // Arithmetic done in 64-bit signed integers; overflow = true result out of 32-bit range
    task automatic ref_alu(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] r, output logic v);
        longint sx, sy, t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v  = 1'b0;
        r  = 32'd0;
        if (ctl == 3'b010 || ctl == 3'b110) begin
            t = (ctl == 3'b010) ? sx + sy : sx - sy;
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            r = t[31:0];
        end else if (ctl == 3'b000) r = x & y;
        else if (ctl == 3'b001) r = x | y;
        else if (ctl == 3'b100) r = ~(x | y);
        else if (ctl == 3'b111) r = (sx < sy) ? 32'd1 : 32'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rn, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] p, input logic [31:0] imm, input logic we);
        logic [2:0]  c;
        logic [31:0] r;
        logic        v;
        @(negedge clk);
        rst_n = rn; aluop = op; funct = f; a = x; b = y; pc = p; sext_imm = imm; status_we = we;
        #1;
        c = ref_ctl(op, f);
        ref_alu(c, x, y, r, v);
        chk("alu_ctl", {29'd0, alu_ctl}, {29'd0, c});
        chk("result", result, r);
        chk("zero", {31'd0, zero}, {31'd0, (r == 32'd0)});
        chk("pc_plus4", pc_plus4, p + 32'd4);
        chk("branch_target", branch_target, p + 32'd4 + imm * 32'd4);
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
        end else if (we) begin
            exp_n = r[31]; exp_z = (r == 32'd0); exp_v = v;
        end
        chk("flag_n", {31'd0, flag_n}, {31'd0, exp_n});
        chk("flag_z", {31'd0, flag_z}, {31'd0, exp_z});
        chk("flag_v", {31'd0, flag_v}, {31'd0, exp_v});
    endtask

    initial begin
        logic [5:0]  fl [8];
        logic [31:0] edge_v [6];
        logic [31:0] ra, rb;
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000011, 6'b111010};
        edge_v = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};

        // reset wins over status_we with a nonzero result
        step(1'b0, 2'b00, 6'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1);
        chk("rst_flag_n", {31'd0, flag_n}, 32'd0);
        chk("rst_flag_v", {31'd0, flag_v}, 32'd0);

        step(1'b1, 2'b10, 6'b100000, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0);
        chk("t_add_ctl", {29'd0, alu_ctl}, 32'd2);
        chk("t_add_res", result, 32'd12);

        step(1'b1, 2'b01, 6'd0, 32'h1234, 32'h1234, 32'h0, 32'h0, 1'b1);
        chk("t_sub_zero", {31'd0, zero}, 32'd1);
        chk("t_sub_flag_z", {31'd0, flag_z}, 32'd1);

        step(1'b1, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        chk("t_slt_neg", result, 32'd1);
        step(1'b1, 2'b10, 6'b101010, 32'h80000000, 32'h1, 32'h0, 32'h0, 1'b0);
        chk("t_slt_ovf", result, 32'd1);
        step(1'b1, 2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 1'b0);
        chk("t_slt_ovf2", result, 32'd0);

        step(1'b1, 2'b00, 6'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1);
        chk("t_ovf_res", result, 32'h80000000);
        chk("t_ovf_n", {31'd0, flag_n}, 32'd1);
        chk("t_ovf_v", {31'd0, flag_v}, 32'd1);
        chk("t_ovf_z", {31'd0, flag_z}, 32'd0);

        step(1'b1, 2'b11, 6'd0, 32'h3, 32'h4, 32'h10, 32'hFFFFFFFE, 1'b0);
        chk("t_pc4", pc_plus4, 32'h14);
        chk("t_bt", branch_target, 32'h0C);
        chk("t_hold_v", {31'd0, flag_v}, 32'd1);

        step(1'b1, 2'b10, 6'b100111, 32'h0F0F0000, 32'h000000F0, 32'h0, 32'h0, 1'b1);
        chk("t_nor", result, 32'hF0F0FF0F);
        step(1'b0, 2'b10, 6'b100111, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("t_rst_n", {31'd0, flag_n}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            step(($urandom_range(0, 19) != 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1) ? fl[$urandom_range(0, 7)] : 6'($urandom),
                 ra, rb, $urandom, $urandom, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
